jtframe_mister_ctrl: RTL and testbench

- System-control block for the MiSTer frame: supervises PLL lock, generates system and game resets, and reads an optional DB15 serial joystick adapter on the user port.
- Sits between the PLL/HPS status interface and the game core, entirely in the clk_sys domain.

---
 rtl/jtframe_mister_ctrl.sv | 172 +++++++++++++++++
 tb/tb_jtframe_mister_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_mister_ctrl.sv
// MiSTer system control: PLL supervision, system/game reset generation and the DB15 serial joystick reader.
// The DB15 reader is only built when JTFRAME_DB15_EN is defined; otherwise its outputs are idle constants.
module jtframe_mister_ctrl #(
  parameter int RST_CYCLES = 256,
  parameter int JOY_DIV    = 64
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        pll_locked,
  output logic        pll_rst,
  input  logic        rst_req,
  input  logic        downloading,
  input  logic [1:0]  status_db15,
  output logic        rst,
  output logic        rst_n,
  output logic        game_rst,
  output logic        game_rst_n,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  input  logic        JOY_DATA,
  output logic [6:0]  USER_OUT,
  output logic        USER_MODE,
  output logic [11:0] joy1_db,
  output logic [11:0] joy2_db,
  output logic        joy_valid
);

  localparam int RW = $clog2(RST_CYCLES);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

  logic [7:0]    pll_cnt;
  logic          last_locked;
  logic [RW-1:0] rst_cnt;
  logic          rst_cause;

  // A falling edge of pll_locked restarts a 256-cycle PLL reset pulse
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      pll_rst     <= 1'b0;
      pll_cnt     <= 8'hD0;
      last_locked <= 1'b0;
    end else begin
      last_locked <= pll_locked;
      if (last_locked && !pll_locked) begin
        pll_cnt <= 8'hFF;
        pll_rst <= 1'b1;
      end else if (pll_cnt != 8'd0) begin
        pll_cnt <= pll_cnt - 8'd1;
      end else begin
        pll_rst <= 1'b0;
      end
    end
  end

  assign rst_cause = rst_req | ~pll_locked | pll_rst;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      rst     <= 1'b1;
      rst_cnt <= RST_LOAD;
    end else if (rst_cause) begin
      rst     <= 1'b1;
      rst_cnt <= RST_LOAD;
    end else begin
      rst <= rst_cnt != '0;
      if (rst_cnt != '0) rst_cnt <= rst_cnt - RW'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) game_rst <= 1'b1;
    else       game_rst <= rst | downloading;
  end

  assign rst_n      = ~rst;
  assign game_rst_n = ~game_rst;

  assign USER_MODE = |status_db15;
  assign USER_OUT  = USER_MODE ? {5'b11111, JOY_CLK, JOY_LOAD} : 7'h7F;

`ifdef JTFRAME_DB15_EN
  localparam int DW = $clog2(JOY_DIV);
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOAD     = 2'd1;
  localparam logic [1:0] ST_SHIFT_LO = 2'd2;
  localparam logic [1:0] ST_SHIFT_HI = 2'd3;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [1:0]    db15_st;
  logic          load_half;
  logic [4:0]    bit_idx;
  logic [23:0]   shift;

  assign tick = div_cnt == DW'(JOY_DIV - 1);

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  // Data is sampled on the same edge that raises JOY_CLK, before the adapter shifts
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      db15_st   <= ST_IDLE;
      JOY_CLK   <= 1'b1;
      JOY_LOAD  <= 1'b1;
      joy1_db   <= 12'h000;
      joy2_db   <= 12'h000;
      joy_valid <= 1'b0;
      load_half <= 1'b0;
      bit_idx   <= 5'd0;
      shift     <= 24'h0;
    end else begin
      joy_valid <= 1'b0;
      if (status_db15 == 2'd0) begin
        db15_st  <= ST_IDLE;
        JOY_CLK  <= 1'b1;
        JOY_LOAD <= 1'b1;
        joy1_db  <= 12'h000;
        joy2_db  <= 12'h000;
      end else begin
        case (db15_st)
          ST_IDLE: begin
            db15_st   <= ST_LOAD;
            JOY_LOAD  <= 1'b0;
            load_half <= 1'b0;
          end
          ST_LOAD: if (tick) begin
            load_half <= 1'b1;
            if (load_half) begin
              JOY_LOAD <= 1'b1;
              JOY_CLK  <= 1'b0;
              bit_idx  <= 5'd0;
              db15_st  <= ST_SHIFT_LO;
            end
          end
          ST_SHIFT_LO: if (tick) begin
            shift[bit_idx] <= JOY_DATA;
            JOY_CLK        <= 1'b1;
            db15_st        <= ST_SHIFT_HI;
          end
          default: if (tick) begin
            if (bit_idx == 5'd23) begin
              joy1_db   <= ~shift[11:0];
              joy2_db   <= status_db15[1] ? ~shift[23:12] : 12'h000;
              joy_valid <= 1'b1;
              JOY_LOAD  <= 1'b0;
              load_half <= 1'b0;
              db15_st   <= ST_LOAD;
            end else begin
              bit_idx <= bit_idx + 5'd1;
              JOY_CLK <= 1'b0;
              db15_st <= ST_SHIFT_LO;
            end
          end
        endcase
      end
    end
  end
`else
  logic unused_joy_data;
  assign unused_joy_data = JOY_DATA;
  assign JOY_CLK   = 1'b1;
  assign JOY_LOAD  = 1'b1;
  assign joy1_db   = 12'h000;
  assign joy2_db   = 12'h000;
  assign joy_valid = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_mister_ctrl.sv
// Bench for jtframe_mister_ctrl: reset timing measurements plus a DB15 adapter model feeding a frame scoreboard.
module tb_jtframe_mister_ctrl;
  localparam int RC = 20;
  localparam int JD = 4;

  logic        clk_sys = 1'b0;
  logic        RESET = 1'b1;
  logic        pll_locked = 1'b1;
  logic        pll_rst;
  logic        rst_req = 1'b0;
  logic        downloading = 1'b0;
  logic [1:0]  status_db15 = 2'd0;
  logic        rst, rst_n, game_rst, game_rst_n;
  logic        JOY_CLK, JOY_LOAD, JOY_DATA;
  logic [6:0]  USER_OUT;
  logic        USER_MODE;
  logic [11:0] joy1_db, joy2_db;
  logic        joy_valid;

  jtframe_mister_ctrl #(.RST_CYCLES(RC), .JOY_DIV(JD)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .rst_req(rst_req), .downloading(downloading), .status_db15(status_db15),
    .rst(rst), .rst_n(rst_n), .game_rst(game_rst), .game_rst_n(game_rst_n),
    .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD), .JOY_DATA(JOY_DATA),
    .USER_OUT(USER_OUT), .USER_MODE(USER_MODE),
    .joy1_db(joy1_db), .joy2_db(joy2_db), .joy_valid(joy_valid)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  int n_pub = 0;
  logic [23:0] exp_q[$];
  logic [23:0] pattern = 24'hFFFFFF;
  logic [23:0] adp_frame = 24'hFFFFFF;
  int adp_idx = 24;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] db15_model(input logic [23:0] pat, input logic [1:0] st);
    logic [11:0] j1, j2;
    j1 = ~pat[11:0];
    j2 = st[1] ? ~pat[23:12] : 12'h000;
    return {j2, j1};
  endfunction

  function automatic logic sel_sig(input int sel);
    if (sel == 0) return rst;
    if (sel == 1) return pll_rst;
    return game_rst;
  endfunction

  // Number of clock cycles until the selected signal reads low (bound+1 on timeout)
  task automatic count_low(input int sel, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (sel_sig(sel) && n <= bound);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // DB15 adapter: LOAD latches the frame, each JOY_CLK rise shifts to the next bit
  assign JOY_DATA = (adp_idx < 24) ? adp_frame[adp_idx] : 1'b1;

  always @(negedge JOY_LOAD) begin
    adp_idx   = 0;
    adp_frame = pattern;
    if (status_db15 != 2'd0) exp_q.push_back(db15_model(pattern, status_db15));
  end

  always @(posedge JOY_CLK) if (JOY_LOAD === 1'b1) adp_idx++;

  always @(negedge clk_sys) begin
    if (joy_valid === 1'b1) begin
      logic [23:0] e;
      n_pub++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_joy_valid actual=%0h required=none", {joy2_db, joy1_db});
      end else begin
        e = exp_q.pop_front();
        check("joy1_db", {20'h0, joy1_db}, {20'h0, e[11:0]});
        check("joy2_db", {20'h0, joy2_db}, {20'h0, e[23:12]});
      end
    end
  end

  task automatic wait_frames(input int frames);
    int target;
    int c;
    target = n_pub + frames;
    c = 0;
    while (n_pub < target && c < frames * (50 * JD + 20) + 50) begin
      @(negedge clk_sys);
      c++;
    end
    if (n_pub < target) begin
      checks++;
      failures++;
      $display("FAIL db15_frame_timeout actual=%0d required=%0d", n_pub, target);
    end
  endtask

  task automatic run_phase(input logic [1:0] st, input logic [23:0] pat);
    status_db15 = 2'd0;
    idle(2);
    exp_q.delete();
    pattern = pat;
    status_db15 = st;
    wait_frames(2);
    check("db15_user_out_hi", {27'h0, USER_OUT[6:2]}, 32'h1F);
  endtask

  initial begin
    int n, len;
    logic [1:0] st;
    idle(3);
    check("reset_rst", {31'h0, rst}, 32'd1);
    check("reset_rst_n", {31'h0, rst_n}, 32'd0);
    check("reset_game_rst", {31'h0, game_rst}, 32'd1);
    check("reset_pll_rst", {31'h0, pll_rst}, 32'd0);
    check("reset_joy", {6'h0, JOY_CLK, JOY_LOAD, joy_valid, joy2_db, joy1_db}, {6'h0, 1'b1, 1'b1, 1'b0, 24'h0});
    RESET = 1'b0;
    count_low(0, 4 * RC, n);
    check("rst_release_cycles", n, RC);
    check("game_rst_lag", {31'h0, game_rst}, 32'd1);
    check("pll_rst_quiet", {31'h0, pll_rst}, 32'd0);
    idle(1);
    check("game_rst_fall", {30'h0, game_rst, game_rst_n}, 32'd1);

    // Single-cycle lock loss, repeated with random gaps
    for (int i = 0; i < 2; i++) begin
      idle($urandom_range(3, 20));
      pll_locked = 1'b0;
      idle(1);
      pll_locked = 1'b1;
      check("pll_rst_rise", {31'h0, pll_rst}, 32'd1);
      count_low(1, 400, n);
      check("pll_rst_len", n, 256);
      count_low(0, 4 * RC, n);
      check("rst_after_pll", n, RC);
    end

    // A second loss mid-countdown restarts the 256-cycle pulse
    idle(5);
    pll_locked = 1'b0;
    idle(1);
    pll_locked = 1'b1;
    idle($urandom_range(20, 200));
    pll_locked = 1'b0;
    idle(1);
    pll_locked = 1'b1;
    count_low(1, 400, n);
    check("pll_rst_reload_len", n, 256);
    count_low(0, 4 * RC, n);
    check("rst_after_reload", n, RC);

    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(2, 10));
      len = $urandom_range(1, 30);
      rst_req = 1'b1;
      idle(len);
      check("rst_during_req", {31'h0, rst}, 32'd1);
      rst_req = 1'b0;
      count_low(0, 4 * RC, n);
      check("rst_after_req", n, RC);
      idle(1);
      check("game_rst_after_req", {31'h0, game_rst}, 32'd0);
    end

    idle(3);
    downloading = 1'b1;
    idle(1);
    check("dl_game_rst", {30'h0, game_rst, game_rst_n}, 32'd2);
    idle($urandom_range(1, 20));
    check("dl_hold", {30'h0, game_rst, rst}, 32'd2);
    downloading = 1'b0;
    idle(1);
    check("dl_release", {30'h0, game_rst, rst}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      st = 2'($urandom_range(0, 3));
      status_db15 = st;
      idle(1);
      check("user_mode", {31'h0, USER_MODE}, {31'h0, st != 2'd0});
      if (st == 2'd0) check("user_out_off", {25'h0, USER_OUT}, 32'h7F);
      else            check("user_out_hi", {27'h0, USER_OUT[6:2]}, 32'h1F);
`ifndef JTFRAME_DB15_EN
      check("user_out_const", {25'h0, USER_OUT}, 32'h7F);
      check("joy_const", {6'h0, JOY_CLK, JOY_LOAD, joy_valid, joy2_db, joy1_db}, {6'h0, 1'b1, 1'b1, 1'b0, 24'h0});
`endif
    end
    status_db15 = 2'd0;
    idle(2);
    exp_q.delete();

`ifdef JTFRAME_DB15_EN
    run_phase(2'd1, 24'hFFFFFE);
    run_phase(2'd2, 24'h7FEFFF);
    for (int i = 0; i < 4; i++) run_phase(2'($urandom_range(1, 3)), 24'($urandom));

    // Abort mid-shift after a frame has been published
    status_db15 = 2'd0;
    idle(2);
    exp_q.delete();
    pattern = 24'($urandom) & 24'hFFFFFE;
    status_db15 = 2'd1;
    wait_frames(1);
    idle(100);
    status_db15 = 2'd0;
    idle(1);
    exp_q.delete();
    check("abort_pins", {30'h0, JOY_CLK, JOY_LOAD}, 32'd3);
    check("abort_joy", {8'h0, joy2_db, joy1_db}, 32'h0);
    check("abort_user", {24'h0, USER_MODE, USER_OUT}, 32'h7F);
    n = n_pub;
    idle(300);
    check("idle_no_publish", n_pub, n);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
